// File: rtl/frame_sched_pkg.sv
// Shared types and width helpers for the frame-buffer scheduler.
package frame_sched_pkg;

    localparam int unsigned DEF_NUM_BUF = 4;

    // Bits needed to index a ring of n buffers (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a committed-buffer count of 0..n.
    function automatic int unsigned fill_width(input int unsigned n);
        return idx_width(n) + 1;
    endfunction

    localparam int unsigned DEF_IDX_W  = idx_width(DEF_NUM_BUF);
    localparam int unsigned DEF_FILL_W = fill_width(DEF_NUM_BUF);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ARM,
        XFER,
        COMMIT
    } state_t;

endpackage

// File: rtl/frame_buf_sched_if.sv
// Sensor, DMA and host-facing signals of the frame-buffer scheduler.
// master: the scheduler side; slave: sensor/DMA/host side.
interface frame_buf_sched_if #(
    parameter int unsigned NUM_BUF = frame_sched_pkg::DEF_NUM_BUF,
    parameter int unsigned ADDR_W  = 32
) ();
    import frame_sched_pkg::*;

    localparam int unsigned IDX_W  = idx_width(NUM_BUF);
    localparam int unsigned FILL_W = fill_width(NUM_BUF);

    logic              enable_i;
    logic              sof_i;
    logic              dma_req_o;
    logic [ADDR_W-1:0] dma_addr_o;
    logic              dma_ack_i;
    logic              dma_done_i;
    logic              rdy_valid_o;
    logic [IDX_W-1:0]  rdy_idx_o;
    logic              release_i;
    logic [FILL_W-1:0] fill_o;
    logic [31:0]       frame_cnt_o;
    logic [31:0]       drop_cnt_o;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        input  enable_i, sof_i, dma_ack_i, dma_done_i, release_i,
        output dma_req_o, dma_addr_o, rdy_valid_o, rdy_idx_o, fill_o,
               frame_cnt_o, drop_cnt_o, busy_o, timeout_o
    );

    modport slave (
        output enable_i, sof_i, dma_ack_i, dma_done_i, release_i,
        input  dma_req_o, dma_addr_o, rdy_valid_o, rdy_idx_o, fill_o,
               frame_cnt_o, drop_cnt_o, busy_o, timeout_o
    );

endinterface

// File: rtl/frame_buf_sched_buf_ring_ptr.sv
// Ring bookkeeping: write/read pointers and committed-buffer count.
// A commit and a release in the same cycle move both pointers and leave
// the count unchanged; a release with nothing committed is ignored.
module buf_ring_ptr
    import frame_sched_pkg::*;
#(
    parameter int unsigned NUM_BUF = DEF_NUM_BUF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          commit,
    input  logic                          rel,
    output logic [idx_width(NUM_BUF)-1:0]  wr_ptr,
    output logic [idx_width(NUM_BUF)-1:0]  rd_ptr,
    output logic [fill_width(NUM_BUF)-1:0] fill,
    output logic                          not_empty
);
    localparam int unsigned IDX_W  = idx_width(NUM_BUF);
    localparam int unsigned FILL_W = fill_width(NUM_BUF);

    logic              rel_ok;
    logic [FILL_W-1:0] fill_next;

    // Next fill count from the commit/release combination.
    always_comb begin
        rel_ok    = rel && (fill != '0);
        fill_next = fill;
        unique case ({commit, rel_ok})
            2'b10:   fill_next = fill + FILL_W'(1);
            2'b01:   fill_next = fill - FILL_W'(1);
            default: fill_next = fill;
        endcase
    end

    // Pointer and count registers; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            not_empty <= 1'b0;
        end else begin
            if (commit) wr_ptr <= wr_ptr + IDX_W'(1);
            if (rel_ok) rd_ptr <= rd_ptr + IDX_W'(1);
            fill      <= fill_next;
            not_empty <= (fill_next != '0);
        end
    end

endmodule

// File: rtl/frame_buf_sched.sv
// Frame-capture DMA scheduler over a ring of NUM_BUF host buffers.
// Optional watchdog on the DMA request/transfer phase: define FRAME_TIMEOUT_EN.
module frame_buf_sched
    import frame_sched_pkg::*;
#(
    parameter int unsigned       NUM_BUF     = DEF_NUM_BUF,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BUF_BASE    = '0,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = ADDR_W'(32'h0080_0000),
    parameter int unsigned       TIMEOUT_CYC = 250_000_000
) (
    input logic               clk,
    input logic               rst,
    frame_buf_sched_if.master bus
);
    localparam int unsigned IDX_W  = idx_width(NUM_BUF);
    localparam int unsigned FILL_W = fill_width(NUM_BUF);

    state_t            state, state_next;
    logic              commit;
    logic              drop_inc;
    logic              wd_expired;
    logic              full;
    logic [IDX_W-1:0]  wr_ptr, rd_ptr;
    logic [FILL_W-1:0] fill;
    logic              not_empty;
    logic [ADDR_W-1:0] addr_calc;
    logic              req_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       frame_cnt_q, drop_cnt_q;

    buf_ring_ptr #(
        .NUM_BUF(NUM_BUF)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .rel       (bus.release_i),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .fill      (fill),
        .not_empty (not_empty)
    );

    assign full      = (fill == FILL_W'(NUM_BUF));
    assign addr_calc = BUF_BASE + ADDR_W'(wr_ptr) * BUF_STRIDE;

    // Next-state decode; a watchdog expiry abandons the frame as a drop.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        drop_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable_i) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!bus.enable_i) begin
                    state_next = IDLE;
                end else if (bus.sof_i) begin
                    if (full) drop_inc = 1'b1;
                    else      state_next = ARM;
                end
            end
            ARM: begin
                if (wd_expired) begin
                    drop_inc   = 1'b1;
                    state_next = bus.enable_i ? WAIT_SOF : IDLE;
                end else if (bus.dma_ack_i) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (wd_expired) begin
                    drop_inc   = 1'b1;
                    state_next = bus.enable_i ? WAIT_SOF : IDLE;
                end else if (bus.dma_done_i) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = bus.enable_i ? WAIT_SOF : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state  <= state_next;
            req_q  <= (state_next == ARM);
            busy_q <= !(state_next inside {IDLE, WAIT_SOF});
            if (state == WAIT_SOF && state_next == ARM) addr_q <= addr_calc;
            if (commit)   frame_cnt_q <= frame_cnt_q + 32'd1;
            if (drop_inc) drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_q;
    logic        in_dma;

    assign in_dma     = (state == ARM) || (state == XFER);
    assign wd_expired = in_dma && (wd_cnt == 32'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles spent in ARM/XFER; flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_dma && (state_next == ARM || state_next == XFER))
                wd_cnt <= wd_cnt + 32'd1;
            else
                wd_cnt <= '0;
            if (wd_expired) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    // Watchdog limit is kept as a parameter so both builds share one interface.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC == 0);
    assign wd_expired     = 1'b0;
    assign bus.timeout_o  = 1'b0;
`endif

    assign bus.dma_req_o   = req_q;
    assign bus.dma_addr_o  = addr_q;
    assign bus.rdy_valid_o = not_empty;
    assign bus.rdy_idx_o   = rd_ptr;
    assign bus.fill_o      = fill;
    assign bus.frame_cnt_o = frame_cnt_q;
    assign bus.drop_cnt_o  = drop_cnt_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Self-checking bench for frame_buf_sched: frame-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
// Scenario 6 runs only when FRAME_TIMEOUT_EN is defined.
module tb_frame_buf_sched;

    localparam int unsigned NB         = 4;
    localparam int unsigned TB_TIMEOUT = 100;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam logic [31:0] STRIDE     = 32'h0080_0000;

    logic clk;
    logic rst;

    int unsigned errors = 0;
    int unsigned checks = 0;

    frame_buf_sched_if #(.NUM_BUF(NB), .ADDR_W(32)) bus ();

    frame_buf_sched #(
        .NUM_BUF     (NB),
        .ADDR_W      (32),
        .BUF_BASE    (BASE),
        .BUF_STRIDE  (STRIDE),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: counts of committed/released frames and drops, plus
    // the phase of the one frame that can be in flight.
    bit          m_live = 0;
    bit          m_listen, m_req, m_xfer, m_commit, m_to, expire;
    int unsigned m_frames, m_released, m_drops, m_wd, fill_now;
    logic [31:0] m_addr;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_listen = 0; m_req = 0; m_xfer = 0; m_commit = 0; m_to = 0;
            m_frames = 0; m_released = 0; m_drops = 0; m_wd = 0; m_addr = '0;
        end else if (m_live) begin
            fill_now = m_frames - m_released;
            expire   = 0;
`ifdef FRAME_TIMEOUT_EN
            if (m_req || m_xfer) begin
                if (m_wd == TB_TIMEOUT - 1) expire = 1;
                else m_wd++;
            end
`endif
            if (bus.release_i && fill_now != 0) m_released++;
            if (m_commit) begin
                m_frames++;
                m_commit = 0;
                m_listen = bus.enable_i;
            end else if (expire) begin
                m_req = 0; m_xfer = 0; m_to = 1; m_drops++;
                m_listen = bus.enable_i;
            end else if (m_xfer) begin
                if (bus.dma_done_i) begin m_xfer = 0; m_commit = 1; end
            end else if (m_req) begin
                if (bus.dma_ack_i) begin m_req = 0; m_xfer = 1; end
            end else if (m_listen) begin
                if (!bus.enable_i) m_listen = 0;
                else if (bus.sof_i) begin
                    if (fill_now < NB) begin
                        m_listen = 0; m_req = 1; m_wd = 0;
                        m_addr = BASE + (m_frames % NB) * STRIDE;
                    end else begin
                        m_drops++;
                    end
                end
            end else if (bus.enable_i) begin
                m_listen = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_req",       bus.dma_req_o,   m_req);
            chk("cyc_addr",      bus.dma_addr_o,  m_addr);
            chk("cyc_busy",      bus.busy_o,      m_req | m_xfer | m_commit);
            chk("cyc_fill",      bus.fill_o,      m_frames - m_released);
            chk("cyc_rdy_valid", bus.rdy_valid_o, (m_frames != m_released));
            chk("cyc_rdy_idx",   bus.rdy_idx_o,   m_released % NB);
            chk("cyc_frame_cnt", bus.frame_cnt_o, m_frames);
            chk("cyc_drop_cnt",  bus.drop_cnt_o,  m_drops);
            chk("cyc_timeout",   bus.timeout_o,   m_to);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: SOF, ack ack_dly cycles after SOF, done done_dly cycles
    // after ack; optional release during COMMIT and stray SOF during XFER.
    task automatic frame(input int ack_dly, input int done_dly, input logic rel_commit,
                         input logic sof_mid, input logic [31:0] exp_addr, input string tag);
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk({tag, "_req"}, bus.dma_req_o, 1);
        chk({tag, "_addr"}, bus.dma_addr_o, exp_addr);
        tick(ack_dly - 1);
        bus.dma_ack_i = 1'b1; tick(); bus.dma_ack_i = 1'b0;
        if (sof_mid) begin
            bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
            tick(done_dly - 2);
        end else begin
            tick(done_dly - 1);
        end
        bus.dma_done_i = 1'b1; tick(); bus.dma_done_i = 1'b0;
        bus.release_i = rel_commit; tick(); bus.release_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        bus.enable_i = 1'b0; bus.sof_i = 1'b0; bus.dma_ack_i = 1'b0;
        bus.dma_done_i = 1'b0; bus.release_i = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_req", bus.dma_req_o, 0);
        chk("rst_fill", bus.fill_o, 0);
        chk("rst_frame_cnt", bus.frame_cnt_o, 0);
        chk("rst_drop_cnt", bus.drop_cnt_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);

        // Disabled: SOF ignored.
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("dis_sof_req", bus.dma_req_o, 0);

        // 1: single frame, stray ack/done beforehand, stray SOF in XFER.
        bus.enable_i = 1'b1; tick(2);
        bus.dma_ack_i = 1'b1; bus.dma_done_i = 1'b1; tick();
        bus.dma_ack_i = 1'b0; bus.dma_done_i = 1'b0;
        chk("t1_stray_busy", bus.busy_o, 0);
        frame(3, 10, 1'b0, 1'b1, 32'h0, "t1");
        chk("t1_rdy_valid", bus.rdy_valid_o, 1);
        chk("t1_rdy_idx", bus.rdy_idx_o, 0);
        chk("t1_frame_cnt", bus.frame_cnt_o, 1);
        chk("t1_drop_cnt", bus.drop_cnt_o, 0);

        // 2: fill the ring, then a dropped SOF.
        frame(1, 2, 1'b0, 1'b0, 32'h0080_0000, "t2a");
        frame(2, 3, 1'b0, 1'b0, 32'h0100_0000, "t2b");
        frame(1, 1, 1'b0, 1'b0, 32'h0180_0000, "t2c");
        chk("t2_fill", bus.fill_o, 4);
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("t2_drop_req", bus.dma_req_o, 0);
        chk("t2_drop_cnt", bus.drop_cnt_o, 1);

        // 3: release to 3, then a frame whose COMMIT coincides with a release.
        bus.release_i = 1'b1; tick(); bus.release_i = 1'b0;
        chk("t3_fill_pre", bus.fill_o, 3);
        chk("t3_idx_pre", bus.rdy_idx_o, 1);
        frame(2, 4, 1'b1, 1'b0, 32'h0, "t3");
        chk("t3_fill", bus.fill_o, 3);
        chk("t3_idx", bus.rdy_idx_o, 2);
        chk("t3_frame_cnt", bus.frame_cnt_o, 5);

        // 4: enable drops during XFER; frame still commits, later SOFs ignored.
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("t4_addr", bus.dma_addr_o, 32'h0080_0000);
        bus.dma_ack_i = 1'b1; tick(); bus.dma_ack_i = 1'b0;
        bus.enable_i = 1'b0; tick(3);
        bus.dma_done_i = 1'b1; tick(); bus.dma_done_i = 1'b0;
        tick();
        chk("t4_frame_cnt", bus.frame_cnt_o, 6);
        chk("t4_busy", bus.busy_o, 0);
        tick(2);
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("t4_sof_req", bus.dma_req_o, 0);
        chk("t4_sof_drop", bus.drop_cnt_o, 1);

        // 5: reset while ARM, then release with empty ring.
        bus.enable_i = 1'b1; tick(2);
        bus.release_i = 1'b1; tick(2); bus.release_i = 1'b0;
        chk("t5_fill_pre", bus.fill_o, 2);
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("t5_arm_req", bus.dma_req_o, 1);
        chk("t5_arm_addr", bus.dma_addr_o, 32'h0100_0000);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_rst_req", bus.dma_req_o, 0);
        chk("t5_rst_frame", bus.frame_cnt_o, 0);
        chk("t5_rst_drop", bus.drop_cnt_o, 0);
        chk("t5_rst_fill", bus.fill_o, 0);
        bus.release_i = 1'b1; tick(); bus.release_i = 1'b0;
        chk("t5_rel_fill", bus.fill_o, 0);
        chk("t5_rel_idx", bus.rdy_idx_o, 0);
        frame(1, 2, 1'b0, 1'b0, 32'h0, "t5b");
        chk("t5b_frame_cnt", bus.frame_cnt_o, 1);

`ifdef FRAME_TIMEOUT_EN
        // 6: no ack; watchdog fires after TB_TIMEOUT cycles in ARM.
        bus.sof_i = 1'b1; tick(); bus.sof_i = 1'b0;
        chk("t6_req", bus.dma_req_o, 1);
        tick(TB_TIMEOUT - 1);
        chk("t6_timeout_before", bus.timeout_o, 0);
        tick();
        chk("t6_timeout", bus.timeout_o, 1);
        chk("t6_req_drop", bus.dma_req_o, 0);
        chk("t6_drop_cnt", bus.drop_cnt_o, 1);
        chk("t6_frame_cnt", bus.frame_cnt_o, 1);
        frame(2, 3, 1'b0, 1'b0, 32'h0080_0000, "t6b");
        chk("t6b_frame_cnt", bus.frame_cnt_o, 2);
        chk("t6b_timeout_sticky", bus.timeout_o, 1);
`endif

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
